// File: rtl/impix_system_pkg.sv
// Shared definitions for the impix system switch-debounce block:
// FSM encodings, default timing constants and a counter-width helper.
package impix_system_pkg;

  // Per-channel debounce FSM encodings.
  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_CHECK = 1'b1;

  typedef enum logic {
    ST_IDLE  = STATE_IDLE,
    ST_CHECK = STATE_CHECK
  } chan_state_e;

  // Defaults: 1 ms sample tick at 50 MHz, 10 stable ticks to accept a level.
  localparam int DEFAULT_TICK_DIV     = 50000;
  localparam int DEFAULT_STABLE_TICKS = 10;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/impix_system_sw_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, IDLE/CHECK FSM and a
// stable-tick counter. sw_clean_o / sw_changed_o are plain register outputs.
//
// Handshake note: tick_i is a one-cycle strobe with no back-pressure;
// sw_changed_o is a one-cycle strobe issued on the same edge that
// updates sw_clean_o. Neither side waits on the other.
module impix_system_sw_debounce_chan
  import impix_system_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw_i,
  input  logic tick_i,
  output logic sw_clean_o,
  output logic sw_changed_o,
  output logic state_o
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  // Count value at which the next tick completes the stable window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic              sync1_q;
  logic              sync2_q;
  chan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clean_q, clean_d;
  logic              changed_q, changed_d;

  // Two-flop synchronizer for the asynchronous switch pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  // Next-state logic: a level must differ from sw_clean for STABLE_TICKS
  // consecutive ticks; any return to the clean level restarts the check.
  // The tick seen on the IDLE->CHECK edge is deliberately ignored, and the
  // counter is cleared on completion so it can never pass STABLE_TICKS.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sync2_q != clean_q) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end
      end
      ST_CHECK: begin
        if (sync2_q == clean_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            clean_d   = sync2_q;
            changed_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_clean_o   = clean_q;
  assign sw_changed_o = changed_q;
  assign state_o      = state_q;

endmodule

// File: rtl/impix_system_sw_debounce.sv
// Multi-channel switch debouncer: one shared sample-tick prescaler feeding
// WIDTH independent debounce channels. fsm_state_o exposes each channel's
// FSM state bit (1 = CHECK) for monitoring.
module impix_system_sw_debounce
  import impix_system_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             tick,
  output logic [WIDTH-1:0] fsm_state_o
);

  localparam int DIV_W = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // Prescaler next state; tick is registered from the next count so that
  // it is high exactly while div_q == TICK_DIV-1 and low during reset.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);
  end

  // Prescaler count and tick strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    impix_system_sw_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .sw_raw_i     (sw_raw[g]),
      .tick_i       (tick_q),
      .sw_clean_o   (sw_clean[g]),
      .sw_changed_o (sw_changed[g]),
      .state_o      (fsm_state_o[g])
    );
  end

endmodule

// File: tb/tb_impix_system_sw_debounce.sv
// Directed bench for impix_system_sw_debounce: a TICK_DIV=4/STABLE_TICKS=3
// instance for the main scenarios and a TICK_DIV=1/STABLE_TICKS=1 instance
// for the minimum-latency case.
module tb_impix_system_sw_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean;
  logic [3:0] sw_changed;
  logic       tick;
  logic [3:0] fsm_state;

  logic [3:0] raw_f;
  logic [3:0] clean_f;
  logic [3:0] changed_f;
  logic       tick_f;
  logic [3:0] state_f;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  impix_system_sw_debounce #(
    .WIDTH        (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_raw      (sw_raw),
    .sw_clean    (sw_clean),
    .sw_changed  (sw_changed),
    .tick        (tick),
    .fsm_state_o (fsm_state)
  );

  impix_system_sw_debounce #(
    .WIDTH        (4),
    .TICK_DIV     (1),
    .STABLE_TICKS (1)
  ) dut_fast (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_raw      (raw_f),
    .sw_clean    (clean_f),
    .sw_changed  (changed_f),
    .tick        (tick_f),
    .fsm_state_o (state_f)
  );

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge at which sw_clean updates after sw_raw changes just after edge c
  // (TICK_DIV=4, STABLE_TICKS=3): sync takes edges c+1,c+2, CHECK is entered
  // on c+3, and ticks are seen on edges that are multiples of 4 after reset.
  function automatic int exp_update(input int c);
    int e;
    int n;
    n = 0;
    for (e = c + 4; e < c + 100; e++) begin
      if (e % 4 == 0) n++;
      if (n == 3) return e;
    end
    return -1;
  endfunction

  // Wait (bounded) for the next sw_changed pulse and check when/what it was.
  task automatic wait_change(input string tag, input logic [3:0] exp_chg,
                             input logic [3:0] exp_clean, input int exp_cyc);
    int n;
    n = 0;
    while (sw_changed == 4'b0000 && n < 64) begin
      step();
      n++;
    end
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_chg"}, sw_changed, exp_chg);
    chk({tag, "_clean"}, sw_clean, exp_clean);
    step();
    chk({tag, "_chg_one"}, sw_changed, 4'b0000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    reset_n = 1'b0;
    sw_raw  = 4'b0000;
    raw_f   = 4'b0000;

    // Reset state.
    repeat (3) step();
    chk("rst_clean", sw_clean, 4'b0000);
    chk("rst_chg", sw_changed, 4'b0000);
    chk("rst_tick", tick, 1'b0);
    chk("rst_state", fsm_state, 4'b0000);
    chk("rst_tick_f", tick_f, 1'b0);

    // Idle run: tick on cycles 3,7,11 after release.
    reset_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("idle_tick_%0d", k), tick, (k % 4 == 3) ? 1'b1 : 1'b0);
      chk($sformatf("idle_clean_%0d", k), sw_clean, 4'b0000);
      chk($sformatf("idle_chg_%0d", k), sw_changed, 4'b0000);
    end

    // Single 0->1 on channel 0.
    sw_raw[0] = 1'b1;
    c = cyc;
    repeat (3) step();
    chk("ch0_in_check", fsm_state, 4'b0001);
    chk("ch0_not_yet", sw_clean, 4'b0000);
    wait_change("ch0_rise", 4'b0001, 4'b0001, exp_update(c));
    chk("ch0_latency_max", ((exp_update(c) - c) <= 15) ? 1'b1 : 1'b0, 1'b1);

    // Bouncing channel 1: toggles every 5 cycles never get accepted.
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) sw_raw[1] = ~sw_raw[1];
      step();
      chk($sformatf("bounce_chg_%0d", i), sw_changed, 4'b0000);
    end
    chk("bounce_clean", sw_clean, 4'b0001);
    sw_raw[1] = 1'b1;
    c = cyc;
    wait_change("ch1_settle", 4'b0010, 4'b0011, exp_update(c));

    // Two channels falling together, then 0000->1010 in one cycle.
    sw_raw = 4'b0000;
    c = cyc;
    wait_change("fall_both", 4'b0011, 4'b0000, exp_update(c));
    sw_raw = 4'b1010;
    c = cyc;
    wait_change("multi_1010", 4'b1010, 4'b1010, exp_update(c));

    // Reset in the middle of a CHECK on channel 2.
    sw_raw = 4'b1110;
    repeat (4) step();
    chk("mid_check_state", fsm_state, 4'b0100);
    chk("mid_check_chg", sw_changed, 4'b0000);
    reset_n = 1'b0;
    #1;
    chk("rst_async_clean", sw_clean, 4'b0000);
    chk("rst_async_chg", sw_changed, 4'b0000);
    chk("rst_async_tick", tick, 1'b0);
    chk("rst_async_state", fsm_state, 4'b0000);
    repeat (2) step();
    chk("rst_hold_chg", sw_changed, 4'b0000);
    chk("rst_hold_clean", sw_clean, 4'b0000);

    // Switches held high through reset appear as a fresh 0->1 change.
    reset_n = 1'b1;
    cyc = 0;
    wait_change("post_rst", 4'b1110, 4'b1110, exp_update(0));

    // Minimum-latency instance: 4 cycles from raw edge to clean.
    chk("fast_tick", tick_f, 1'b1);
    chk("fast_clean0", clean_f, 4'b0000);
    raw_f = 4'b0001;
    c = cyc;
    for (int n = 0; n < 10 && clean_f[0] == 1'b0; n++) step();
    chk("fast_latency", cyc - c, 4);
    chk("fast_chg", changed_f, 4'b0001);
    chk("fast_clean", clean_f, 4'b0001);
    step();
    chk("fast_chg_one", changed_f, 4'b0000);
    chk("fast_tick2", tick_f, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
